// File: rtl/if_fetch_buffer.sv
// Instruction-fetch stage: issues the PC over a req/gnt + rvalid memory port, tracks
// in-flight reads and buffers returned instructions with their addresses for decode.
module if_fetch_buffer #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
  input  logic              clk_100MHz,
  input  logic              arst,
  input  logic [ADDR_W-1:0] pc_addr_i,
  input  logic              flush_i,
  output logic              hold_o,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic              id_valid_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic [ADDR_W-1:0] id_addr_o,
  input  logic              id_ready_i
);

  localparam int unsigned    PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned    CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_X = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [INST_W-1:0] fifoData_q [DEPTH];
  logic [ADDR_W-1:0] fifoAddr_q [DEPTH];
  logic [ADDR_W-1:0] reqAddr_q  [DEPTH];

  logic [PTR_W-1:0] fifoRdPtr_q, fifoRdPtr_d;
  logic [PTR_W-1:0] fifoWrPtr_q, fifoWrPtr_d;
  logic [CNT_W-1:0] fifoCount_q, fifoCount_d;
  logic [PTR_W-1:0] reqRdPtr_q, reqRdPtr_d;
  logic [PTR_W-1:0] reqWrPtr_q, reqWrPtr_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic           headValid;
  logic           pop;
  logic           push;
  logic           issue;
  logic           issueOk;
  logic           dropRsp;
  logic [CNT_W:0] creditUsed;

  // A slot is reserved at issue time, so buffered plus in-flight never exceeds DEPTH.
  assign headValid  = (fifoCount_q != '0);
  assign pop        = headValid & id_ready_i;
  assign creditUsed = {1'b0, fifoCount_q} + {1'b0, outstanding_q} - {{CNT_W{1'b0}}, pop};
  assign issueOk    = (creditUsed < DEPTH_X);

  assign imem_req_o  = ~arst & ~flush_i & issueOk;
  assign imem_addr_o = pc_addr_i;
  assign issue       = imem_req_o & imem_gnt_i;
  assign hold_o      = ~issue;

  assign dropRsp = (discard_q != '0);
  assign push    = imem_rvalid_i & ~dropRsp & ~flush_i;

  assign id_valid_o = headValid;
  assign id_inst_o  = headValid ? fifoData_q[fifoRdPtr_q] : NOP_INST;
  assign id_addr_o  = headValid ? fifoAddr_q[fifoRdPtr_q] : '0;

  always_comb begin
    fifoRdPtr_d   = fifoRdPtr_q;
    fifoWrPtr_d   = fifoWrPtr_q;
    fifoCount_d   = fifoCount_q;
    reqRdPtr_d    = reqRdPtr_q;
    reqWrPtr_d    = reqWrPtr_q;
    outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(imem_rvalid_i);
    discard_d     = discard_q;

    if (issue) begin
      reqWrPtr_d = reqWrPtr_q + PTR_W'(1);
    end
    if (imem_rvalid_i) begin
      reqRdPtr_d = reqRdPtr_q + PTR_W'(1);
    end

    // Every read still in flight after this cycle belongs to the abandoned path.
    if (flush_i) begin
      fifoRdPtr_d = '0;
      fifoWrPtr_d = '0;
      fifoCount_d = '0;
      discard_d   = outstanding_q - CNT_W'(imem_rvalid_i);
    end else begin
      if (push) begin
        fifoWrPtr_d = fifoWrPtr_q + PTR_W'(1);
      end
      if (pop) begin
        fifoRdPtr_d = fifoRdPtr_q + PTR_W'(1);
      end
      fifoCount_d = fifoCount_q + CNT_W'(push) - CNT_W'(pop);
      if (imem_rvalid_i && dropRsp) begin
        discard_d = discard_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_100MHz or posedge arst) begin
    if (arst) begin
      fifoRdPtr_q   <= '0;
      fifoWrPtr_q   <= '0;
      fifoCount_q   <= '0;
      reqRdPtr_q    <= '0;
      reqWrPtr_q    <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fifoRdPtr_q   <= fifoRdPtr_d;
      fifoWrPtr_q   <= fifoWrPtr_d;
      fifoCount_q   <= fifoCount_d;
      reqRdPtr_q    <= reqRdPtr_d;
      reqWrPtr_q    <= reqWrPtr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Storage needs no reset: counts and pointers alone decide what is valid.
  always_ff @(posedge clk_100MHz) begin
    if (push) begin
      fifoData_q[fifoWrPtr_q] <= imem_rdata_i;
      fifoAddr_q[fifoWrPtr_q] <= reqAddr_q[reqRdPtr_q];
    end
    if (issue) begin
      reqAddr_q[reqWrPtr_q] <= pc_addr_i;
    end
  end

  rvalidNeedsRead: assert property (@(posedge clk_100MHz) disable iff (arst)
    imem_rvalid_i |-> (outstanding_q != '0));

  rvalidNotIntoFull: assert property (@(posedge clk_100MHz) disable iff (arst)
    (imem_rvalid_i && !dropRsp && !flush_i) |-> (fifoCount_q != FULL_CNT));

endmodule
